fpu_req_arbiter: RTL and testbench

FPU_REQ_ARBITER -- requirements
Module: fpu_req_arbiter

---
 rtl/fpu_arb_pkg.sv | 24 ++
 rtl/fpu_req_arbiter_if.sv | 58 +++++
 rtl/fpu_arb_rr_pick.sv | 20 ++
 rtl/fpu_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the two-port FPU request arbiter.
// Opcode encodings and the bf16 quiet NaN used for timed-out operations.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int OP_W_DEF = 4;

  localparam logic [OP_W_DEF-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W_DEF-1:0] OP_MUL  = 4'd2;
  localparam logic [OP_W_DEF-1:0] OP_DIV  = 4'd3;
  localparam logic [OP_W_DEF-1:0] OP_SQRT = 4'd4;
  localparam logic [OP_W_DEF-1:0] OP_CMP  = 4'd5;
  localparam logic [OP_W_DEF-1:0] OP_CVT  = 4'd6;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Request, response and FPU-side signals of the arbiter in one bundle.
// slave = arbiter side, master = requesters plus FPU.
interface fpu_req_arbiter_if #(
  parameter int OP_W = fpu_arb_pkg::OP_W_DEF
);

  logic            req0_valid;
  logic            req0_ready;
  logic [OP_W-1:0] req0_op;
  logic [15:0]     req0_a;
  logic [15:0]     req0_b;

  logic            req1_valid;
  logic            req1_ready;
  logic [OP_W-1:0] req1_op;
  logic [15:0]     req1_a;
  logic [15:0]     req1_b;

  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [15:0]     rsp0_result;
  logic            rsp0_err;

  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [15:0]     rsp1_result;
  logic            rsp1_err;

  logic            fpu_start;
  logic [OP_W-1:0] fpu_op;
  logic [15:0]     fpu_a;
  logic [15:0]     fpu_b;
  logic            fpu_done;
  logic [15:0]     fpu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output fpu_start, fpu_op, fpu_a, fpu_b,
    input  fpu_done, fpu_result
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  fpu_start, fpu_op, fpu_a, fpu_b,
    output fpu_done, fpu_result
  );

endinterface

// File: rtl/fpu_arb_rr_pick.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the
// port that was not granted last.
module fpu_arb_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant       = 1'b0;
    grant_valid = |valid;
    unique case (1'b1)
      (valid == 2'b11): grant = ~last_grant;
      (valid == 2'b10): grant = 1'b1;
      default:          grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one FPU between the UART (port 0) and Wishbone (port 1) paths.
// FPU_ARB_TIMEOUT_EN adds a WAIT watchdog answering qNaN with err=1.
module fpu_req_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OP_W           = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fpu_req_arbiter_if.slave  bus
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [15:0]     res_q, res_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;

  logic [1:0]      req_valid;
  logic            pick;
  logic            pick_vld;
  logic            rsp_ready;
  logic            tmo;
  logic            rsp_err;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

  fpu_arb_rr_pick u_pick (
    .valid       (req_valid),
    .last_grant  (last_q),
    .grant       (pick),
    .grant_valid (pick_vld)
  );

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign tmo     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_ISSUE;
          grant_d = pick;
          op_d    = pick ? bus.req1_op : bus.req0_op;
          a_d     = pick ? bus.req1_a  : bus.req0_a;
          b_d     = pick ? bus.req1_b  : bus.req0_b;
        end
      end
      S_ISSUE: begin
        if (bus.fpu_done) begin
          state_d = S_RESP;
          res_d   = bus.fpu_result;
`ifdef FPU_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        // a done arriving together with the timeout still wins
        if (bus.fpu_done) begin
          state_d = S_RESP;
          res_d   = bus.fpu_result;
`ifdef FPU_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else if (tmo) begin
          state_d = S_RESP;
          res_d   = BF16_QNAN;
`ifdef FPU_ARB_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef FPU_ARB_TIMEOUT_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    if (!rst && state_q == S_IDLE && pick_vld) begin
      bus.req0_ready = ~pick;
      bus.req1_ready = pick;
    end
    bus.fpu_start   = (state_q == S_ISSUE);
    bus.fpu_op      = op_q;
    bus.fpu_a       = a_q;
    bus.fpu_b       = b_q;
    bus.rsp0_valid  = (state_q == S_RESP) && !grant_q;
    bus.rsp1_valid  = (state_q == S_RESP) && grant_q;
    bus.rsp0_result = res_q;
    bus.rsp1_result = res_q;
    bus.rsp0_err    = rsp_err;
    bus.rsp1_err    = rsp_err;
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Scoreboard bench for fpu_req_arbiter with a latency-programmable FPU model.
// Timeout checks follow FPU_ARB_TIMEOUT_EN when it is defined.
`timescale 1ns/1ps
module tb_fpu_req_arbiter;
  import fpu_arb_pkg::*;

  localparam int TMO = 8;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  typedef struct packed {
    logic        port;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_req_arbiter_if #(.OP_W(4)) bus();

  fpu_req_arbiter #(
    .TIMEOUT_CYCLES (TMO),
    .OP_W           (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  req_t rq0[$];
  req_t rq1[$];
  exp_t exp_q[$];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  bit hold0     = 1'b0;
  bit hold1     = 1'b0;
  int fpu_lat   = 2;
  int stray_req = 0;
  int stray_ack = 0;
  int t_acc     = -1;
  int t_start   = -1;
  int t_done    = -1;
  int t_rsp     = -1;
  logic [15:0] last_res = 16'h0000;

  function automatic logic [15:0] fake_fpu(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    if (op == OP_ADD && a == 16'h3F80 && b == 16'h4000)
      return 16'h4040;
    return a ^ {b[7:0], b[15:8]} ^ {12'h000, op} ^ 16'h1234;
  endfunction

  task automatic push_req(input bit port, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input bit expect_rsp);
    req_t r;
    exp_t e;
    r = '{op: op, a: a, b: b};
    e = '{port: port, res: fake_fpu(op, a, b), err: 1'b0};
    if (port) rq1.push_back(r);
    else      rq0.push_back(r);
    if (expect_rsp) exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // request / response-ready driver
  initial begin
    bit a0, a1;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    forever begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (a0 && rq0.size() != 0) void'(rq0.pop_front());
      if (a1 && rq1.size() != 0) void'(rq1.pop_front());
      bus.req0_valid = (rq0.size() != 0);
      bus.req1_valid = (rq1.size() != 0);
      if (rq0.size() != 0) {bus.req0_op, bus.req0_a, bus.req0_b} = rq0[0];
      if (rq1.size() != 0) {bus.req1_op, bus.req1_a, bus.req1_b} = rq1[0];
      bus.rsp0_ready = !hold0;
      bus.rsp1_ready = !hold1;
    end
  end

  // FPU model: done fpu_lat cycles after start, -1 = never
  initial begin
    int cnt;
    logic [15:0] pend;
    cnt = 0;
    pend = '0;
    bus.fpu_done = 1'b0;
    bus.fpu_result = '0;
    forever begin
      @(posedge clk); #1;
      bus.fpu_done = 1'b0;
      if (rst) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.fpu_done = 1'b1;
          bus.fpu_result = pend;
        end
      end
      if (bus.fpu_start) begin
        pend = fake_fpu(bus.fpu_op, bus.fpu_a, bus.fpu_b);
        if (fpu_lat == 0) begin
          bus.fpu_done = 1'b1;
          bus.fpu_result = pend;
        end else if (fpu_lat > 0) begin
          cnt = fpu_lat;
        end
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        bus.fpu_done = 1'b1;
        bus.fpu_result = 16'hDEAD;
      end
    end
  end

  // response monitor and scoreboard
  initial begin
    bit prev_start, prev_rv;
    exp_t e;
    prev_start = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
        t_acc = cyc;
      if (bus.fpu_start) begin
        t_start = cyc;
        checks++;
        if (prev_start !== 1'b0) begin
          failures++;
          $display("FAIL start_pulse: fpu_start high %0d cycles in a row, required 1", 2);
        end
      end
      prev_start = bus.fpu_start;
      if (bus.fpu_done) t_done = cyc;
      if ((bus.rsp0_valid || bus.rsp1_valid) && !prev_rv) t_rsp = cyc;
      prev_rv = bus.rsp0_valid || bus.rsp1_valid;
      if (bus.rsp0_valid && bus.rsp1_valid) begin
        checks++;
        failures++;
        $display("FAIL rsp_exclusive: both rsp valid, required at most one");
      end else if ((bus.rsp0_valid && bus.rsp0_ready) ||
                   (bus.rsp1_valid && bus.rsp1_ready)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: port=%0d result=%h, required no response",
                   bus.rsp1_valid, bus.rsp1_valid ? bus.rsp1_result : bus.rsp0_result);
        end else begin
          e = exp_q.pop_front();
          last_res = e.res;
          if (bus.rsp1_valid !== e.port ||
              (e.port ? bus.rsp1_result : bus.rsp0_result) !== e.res ||
              (e.port ? bus.rsp1_err : bus.rsp0_err) !== e.err) begin
            failures++;
            $display("FAIL rsp_data: port=%0d result=%h err=%b, required port=%0d result=%h err=%b",
                     bus.rsp1_valid, e.port ? bus.rsp1_result : bus.rsp0_result,
                     e.port ? bus.rsp1_err : bus.rsp0_err, e.port, e.res, e.err);
          end
        end
      end
    end
  end

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d responses outstanding after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    fpu_lat = 2;
    push_req(1'b0, OP_ADD, 16'h4000, 16'h4040, 1'b1);
    push_req(1'b1, OP_MUL, 16'h3F00, 16'h4100, 1'b1);
    push_req(1'b0, OP_SUB, 16'h4080, 16'h3F80, 1'b1);
    push_req(1'b1, OP_DIV, 16'h4120, 16'h4000, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: ready=%b%b, required 00", bus.req1_ready, bus.req0_ready);
    end
    checks++;
    if (bus.fpu_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_start: fpu_start=%b, required 0", bus.fpu_start);
    end
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_valid: %b%b, required 00", bus.rsp1_valid, bus.rsp0_valid);
    end
    checks++;
    if (bus.rsp0_result !== 16'h0000 || bus.rsp1_result !== 16'h0000 ||
        bus.rsp0_err !== 1'b0 || bus.rsp1_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_data: result=%h err=%b, required 0000 0",
               bus.rsp0_result, bus.rsp0_err);
    end
    checks++;
    if (bus.fpu_op !== 4'h0 || bus.fpu_a !== 16'h0000 || bus.fpu_b !== 16'h0000) begin
      failures++;
      $display("FAIL reset_fpu_bus: op=%h a=%h b=%h, required 0 0000 0000",
               bus.fpu_op, bus.fpu_a, bus.fpu_b);
    end
  endtask

  task automatic test_round_robin;
    @(posedge clk); #1;
    rst = 1'b0;
    drain(200, "round_robin");
  endtask

  task automatic test_single;
    fpu_lat = 3;
    push_req(1'b0, OP_ADD, 16'h3F80, 16'h4000, 1'b1);
    drain(100, "single");
    checks++;
    if (t_start !== t_acc + 1) begin
      failures++;
      $display("FAIL single_start_latency: start at %0d, required %0d", t_start, t_acc + 1);
    end
    checks++;
    if (t_done !== t_start + 3) begin
      failures++;
      $display("FAIL single_done_time: done at %0d, required %0d", t_done, t_start + 3);
    end
    checks++;
    if (t_rsp !== t_done + 1) begin
      failures++;
      $display("FAIL single_rsp_latency: rsp at %0d, required %0d", t_rsp, t_done + 1);
    end
    checks++;
    if (bus.fpu_op !== OP_ADD || bus.fpu_a !== 16'h3F80 || bus.fpu_b !== 16'h4000) begin
      failures++;
      $display("FAIL single_fpu_hold: op=%h a=%h b=%h, required 0 3f80 4000",
               bus.fpu_op, bus.fpu_a, bus.fpu_b);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] want;
    int n;
    hold1 = 1'b1;
    fpu_lat = 2;
    want = fake_fpu(OP_MUL, 16'h4040, 16'h4000);
    push_req(1'b1, OP_MUL, 16'h4040, 16'h4000, 1'b1);
    n = 0;
    while (bus.rsp1_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp1_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_rsp_arrive: rsp1_valid=%b after 50 cycles, required 1", bus.rsp1_valid);
    end
    push_req(1'b0, OP_SUB, 16'h4100, 16'h3F80, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== want) begin
        failures++;
        $display("FAIL bp_hold_%0d: rsp1_valid=%b result=%h, required 1 %h",
                 i, bus.rsp1_valid, bus.rsp1_result, want);
      end
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall_%0d: req0_ready=%b rsp0_valid=%b, required 0 0",
                 i, bus.req0_ready, bus.rsp0_valid);
      end
    end
    @(posedge clk); #1;
    hold1 = 1'b0;
    drain(100, "backpressure");
  endtask

  task automatic test_timeout;
    fpu_lat = -1;
`ifdef FPU_ARB_TIMEOUT_EN
    push_req(1'b0, OP_DIV, 16'h3F80, 16'h0000, 1'b0);
    exp_q.push_back('{port: 1'b0, res: BF16_QNAN, err: 1'b1});
    drain(100, "timeout");
    checks++;
    if (t_rsp !== t_start + 1 + TMO) begin
      failures++;
      $display("FAIL timeout_latency: rsp at %0d, required %0d", t_rsp, t_start + 1 + TMO);
    end
`else
    begin
      int seen;
      seen = 0;
      push_req(1'b0, OP_DIV, 16'h3F80, 16'h0000, 1'b0);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.rsp0_valid || bus.rsp1_valid) seen++;
      end
      checks++;
      if (seen != 0 || bus.fpu_op !== OP_DIV || bus.fpu_a !== 16'h3F80) begin
        failures++;
        $display("FAIL no_timeout_wait: rsp seen %0d op=%h a=%h, required 0 3 3f80",
                 seen, bus.fpu_op, bus.fpu_a);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
    end
`endif
    fpu_lat = TMO;
    push_req(1'b1, OP_SQRT, 16'h4080, 16'h0000, 1'b1);
    drain(100, "done_vs_timeout");
    checks++;
    if (t_rsp !== t_done + 1 || t_done !== t_start + TMO) begin
      failures++;
      $display("FAIL done_vs_timeout_time: done=%0d rsp=%0d, required %0d %0d",
               t_done, t_rsp, t_start + TMO, t_start + TMO + 1);
    end
  endtask

  task automatic test_rst_wait;
    int seen;
    fpu_lat = -1;
    push_req(1'b0, OP_CMP, 16'h4000, 16'h3F80, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (bus.fpu_start !== 1'b0 || bus.fpu_op !== OP_CMP || bus.rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstw_in_wait: start=%b op=%h rsp0_valid=%b, required 0 5 0",
               bus.fpu_start, bus.fpu_op, bus.rsp0_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stray_req++;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid || bus.fpu_start) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rstw_no_rsp: %0d cycles with activity, required 0", seen);
    end
    checks++;
    if (bus.fpu_op !== 4'h0 || bus.rsp0_result !== 16'h0000) begin
      failures++;
      $display("FAIL rstw_cleared: op=%h result=%h, required 0 0000",
               bus.fpu_op, bus.rsp0_result);
    end
    fpu_lat = 2;
    push_req(1'b1, OP_CVT, 16'h4248, 16'h0000, 1'b1);
    drain(100, "rst_wait");
  endtask

  task automatic test_idle_done;
    @(posedge clk); #1;
    stray_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.fpu_start !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
          bus.rsp1_result !== last_res) begin
        failures++;
        $display("FAIL idle_done_%0d: start=%b rv=%b%b result=%h, required 0 00 %h",
                 i, bus.fpu_start, bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_result, last_res);
      end
    end
    fpu_lat = 1;
    push_req(1'b0, OP_MUL, 16'h3FC0, 16'h4000, 1'b1);
    push_req(1'b1, OP_ADD, 16'h4000, 16'h4000, 1'b1);
    drain(100, "idle_done");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_timeout();
    test_rst_wait();
    test_idle_done();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expected responses never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
